// File: rtl/stream_to_bram.sv
// Captures a burst of AXI-stream words into a BRAM port, started by an arm pulse
// and optionally gated by the orbit sync fast command.
module stream_to_bram #(
    parameter int MEM_DEPTH = 2048,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        abort,
    input  logic        trig_mode,
    input  logic [15:0] capture_length,
    input  logic        fc_orbitSync,
    input  logic [31:0] data_stream_TDATA,
    input  logic        data_stream_TVALID,
    output logic        data_stream_TREADY,
    output logic        bram_CLK,
    output logic        bram_RST,
    output logic        bram_EN,
    output logic [3:0]  bram_WE,
    output logic [31:0] bram_ADDR,
    output logic [31:0] bram_DIN,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_count,
    output logic [1:0]  dbg_state
);

    // Stream handshake: a beat is accepted whenever TVALID and TREADY are both
    // high on a rising edge; TREADY is high at all times outside reset.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(MEM_DEPTH);

    state_t        state_q;
    logic          sync_q;
    logic          mode_q;
    logic [16:0]   len_q;
    logic [AW-1:0] waddr_q;
    logic [15:0]   wc_q;
    logic          en_q;
    logic [31:0]   addr_q;
    logic [31:0]   din_q;
    logic          busy_q;
    logic          done_q;

    logic          beat_acc;
    logic          trig_hit;
    logic          take_beat;
    logic          last_beat;
    logic          arm_ok;
    logic [16:0]   len_d;
    logic [16:0]   wc_next;

    assign data_stream_TREADY = ~reset;
    assign beat_acc  = data_stream_TVALID & data_stream_TREADY;
    assign trig_hit  = ~mode_q | sync_q;
    assign take_beat = beat_acc & ((state_q == S_CAPTURE) |
                                   ((state_q == S_ARMED) & trig_hit));
    assign arm_ok    = arm & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign wc_next   = {1'b0, wc_q} + 17'd1;
    // >= keeps the last-word test safe even if len_q were ever below the count.
    assign last_beat = (wc_next >= len_q);

    // Zero or oversized lengths fill the whole buffer.
    assign len_d = ((capture_length == 16'd0) || ({1'b0, capture_length} > DEPTH_L))
                   ? DEPTH_L : {1'b0, capture_length};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sync_q  <= 1'b0;
            mode_q  <= 1'b0;
            len_q   <= 17'd0;
            waddr_q <= '0;
            wc_q    <= 16'd0;
            en_q    <= 1'b0;
            addr_q  <= 32'd0;
            din_q   <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sync_q <= fc_orbitSync;
            en_q   <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (arm_ok) begin
                mode_q  <= trig_mode;
                len_q   <= len_d;
                wc_q    <= 16'd0;
                waddr_q <= '0;
                state_q <= S_ARMED;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end else if (take_beat) begin
                en_q    <= 1'b1;
                addr_q  <= 32'({waddr_q, 2'b00});
                din_q   <= data_stream_TDATA;
                waddr_q <= waddr_q + AW'(1);
                wc_q    <= wc_q + 16'd1;
                if (last_beat) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= S_CAPTURE;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
            end
        end
    end

    assign bram_CLK   = clk;
    assign bram_RST   = reset;
    assign bram_EN    = en_q;
    assign bram_WE    = {4{en_q}};
    assign bram_ADDR  = addr_q;
    assign bram_DIN   = din_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = wc_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_stream_to_bram.sv
// Bench for stream_to_bram: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the capture rules.
module tb_stream_to_bram;

    localparam int DEPTH = 2048;

    logic        clk;
    logic        reset;
    logic        arm;
    logic        abort;
    logic        trig_mode;
    logic [15:0] capture_length;
    logic        fc_orbitSync;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        bram_CLK;
    logic        bram_RST;
    logic        bram_EN;
    logic [3:0]  bram_WE;
    logic [31:0] bram_ADDR;
    logic [31:0] bram_DIN;
    logic        busy;
    logic        done;
    logic [15:0] word_count;
    logic [1:0]  dbg_state;

    stream_to_bram #(.MEM_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .arm                (arm),
        .abort              (abort),
        .trig_mode          (trig_mode),
        .capture_length     (capture_length),
        .fc_orbitSync       (fc_orbitSync),
        .data_stream_TDATA  (tdata),
        .data_stream_TVALID (tvalid),
        .data_stream_TREADY (tready),
        .bram_CLK           (bram_CLK),
        .bram_RST           (bram_RST),
        .bram_EN            (bram_EN),
        .bram_WE            (bram_WE),
        .bram_ADDR          (bram_ADDR),
        .bram_DIN           (bram_DIN),
        .busy               (busy),
        .done               (done),
        .word_count         (word_count),
        .dbg_state          (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=IDLE 1=ARMED 2=CAPTURE 3=DONE; each captured
    // word k lands at byte address 4*k and is visible on the BRAM port the
    // cycle after the edge that accepted it.
    int          m_phase     = 0;
    int          m_cnt       = 0;
    int          m_len       = 0;
    bit          m_mode      = 1'b0;
    bit          m_prev_sync = 1'b0;
    bit          m_en        = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] act_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase     = 0;
            m_cnt       = 0;
            m_en        = 1'b0;
            m_prev_sync = 1'b0;
            exp_q.delete();
        end else begin
            m_en = 1'b0;
            if (abort) begin
                m_phase = 0;
            end else if (arm && (m_phase == 0 || m_phase == 3)) begin
                m_mode  = trig_mode;
                m_len   = (capture_length == 0 || int'(capture_length) > DEPTH)
                          ? DEPTH : int'(capture_length);
                m_cnt   = 0;
                m_phase = 1;
            end else if (tvalid && (m_phase == 2 ||
                                    (m_phase == 1 && (!m_mode || m_prev_sync)))) begin
                exp_q.push_back({32'(m_cnt * 4), tdata});
                m_cnt   = m_cnt + 1;
                m_en    = 1'b1;
                m_phase = (m_cnt == m_len) ? 3 : 2;
            end
            m_prev_sync = fc_orbitSync;
        end
    end

    // scoreboard / compare, away from the active edge
    always @(negedge clk) begin
        logic [63:0] e;
        chk("tready", 64'(tready), 64'(!reset));
        chk("bram_rst", 64'(bram_RST), 64'(reset));
        chk("bram_en", 64'(bram_EN), 64'(m_en));
        chk("bram_we", 64'(bram_WE), 64'({4{m_en}}));
        chk("word_count", 64'(word_count), 64'(m_cnt[15:0]));
        chk("busy", 64'(busy), 64'(m_phase == 1 || m_phase == 2));
        chk("done", 64'(done), 64'(m_phase == 3));
        chk("state", 64'(dbg_state), 64'(m_phase[1:0]));
        if (reset) begin
            chk("rst_addr", 64'(bram_ADDR), 64'd0);
            chk("rst_din", 64'(bram_DIN), 64'd0);
        end
        if (m_en) begin
            if (exp_q.size() == 0) begin
                chk("exp_q_empty", 64'd0, 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("bram_addr", 64'(bram_ADDR), 64'(e[63:32]));
                chk("bram_din", 64'(bram_DIN), 64'(e[31:0]));
            end
        end
        if (bram_EN) act_q.push_back({bram_ADDR, bram_DIN});
    end

    // driver tasks
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_arm(input bit mode, input logic [15:0] len);
        trig_mode      = mode;
        capture_length = len;
        arm            = 1'b1;
        tvalid         = 1'b0;
        fc_orbitSync   = 1'b0;
        tick();
        arm = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input bit v = 1'b1, input bit s = 1'b0);
        tdata        = d;
        tvalid       = v;
        fc_orbitSync = s;
        tick();
    endtask

    task automatic quiet(input int n);
        tvalid       = 1'b0;
        fc_orbitSync = 1'b0;
        tick(n);
    endtask

    initial begin
        logic [15:0] big_len[4];
        big_len = '{16'd2047, 16'd2048, 16'd2049, 16'd5000};
        reset = 1'b1; arm = 1'b0; abort = 1'b0; trig_mode = 1'b0;
        capture_length = 16'd0; fc_orbitSync = 1'b0; tdata = 32'd0; tvalid = 1'b0;
        tick(3);
        #1;
        chk("reset_tready", 64'(tready), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        tick();
        chk("post_reset_tready", 64'(tready), 64'd1);
        chk("post_reset_wc", 64'(word_count), 64'd0);
        chk("bram_clk_follows", 64'(bram_CLK), 64'(clk));

        // immediate trigger, length 4
        act_q.delete();
        do_arm(1'b0, 16'd4);
        for (int i = 0; i < 6; i++) beat(32'hA0 + 32'(i));
        quiet(2);
        chk("imm_writes", 64'(act_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < act_q.size(); i++)
            chk("imm_word", act_q[i], {32'(i * 4), 32'hA0 + 32'(i)});
        chk("imm_done", 64'(done), 64'd1);
        chk("imm_wc", 64'(word_count), 64'd4);

        // orbit trigger, re-armed from DONE
        act_q.delete();
        do_arm(1'b1, 16'd3);
        beat(32'h11);
        beat(32'h55, 1'b1, 1'b1);
        beat(32'h66);
        beat(32'h67);
        beat(32'h68);
        beat(32'h69);
        quiet(2);
        chk("orbit_writes", 64'(act_q.size()), 64'd3);
        if (act_q.size() == 3) begin
            chk("orbit_w0", act_q[0], {32'h0, 32'h66});
            chk("orbit_w1", act_q[1], {32'h4, 32'h67});
            chk("orbit_w2", act_q[2], {32'h8, 32'h68});
        end

        // length clamp for 0 and oversize
        foreach (big_len[k]) begin
            if (k == 0) continue;
        end
        for (int k = 0; k < 2; k++) begin
            act_q.delete();
            do_arm(1'b0, (k == 0) ? 16'd0 : 16'd5000);
            for (int i = 0; i < 2100; i++) beat($urandom);
            quiet(2);
            chk("clamp_writes", 64'(act_q.size()), 64'd2048);
            if (act_q.size() > 0) begin
                chk("clamp_first_addr", 64'(act_q[0][63:32]), 64'h0);
                chk("clamp_last_addr", 64'(act_q[act_q.size() - 1][63:32]), 64'h1FFC);
            end
            chk("clamp_wc", 64'(word_count), 64'd2048);
        end

        // gapped stream then abort after three writes
        act_q.delete();
        do_arm(1'b0, 16'd8);
        for (int i = 0; i < 6; i++) beat(32'hB0 + 32'(i), (i % 2) == 0);
        tdata = 32'hBF; tvalid = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 6; i++) beat(32'hC0 + 32'(i), (i % 2) == 0);
        quiet(2);
        chk("abort_state", 64'(dbg_state), 64'd0);
        chk("abort_wc", 64'(word_count), 64'd3);
        chk("abort_writes", 64'(act_q.size()), 64'd3);
        if (act_q.size() == 3) chk("abort_w2", act_q[2], {32'h8, 32'hB4});

        // reset in the middle of a capture
        do_arm(1'b0, 16'd8);
        for (int i = 0; i < 4; i++) beat(32'hD0 + 32'(i));
        reset = 1'b1;
        act_q.delete();
        #1;
        chk("midrst_en", 64'(bram_EN), 64'd0);
        chk("midrst_we", 64'(bram_WE), 64'd0);
        chk("midrst_addr", 64'(bram_ADDR), 64'd0);
        chk("midrst_din", 64'(bram_DIN), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_wc", 64'(word_count), 64'd0);
        chk("midrst_tready", 64'(tready), 64'd0);
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) beat(32'hE0 + 32'(i));
        quiet(2);
        chk("midrst_no_writes", 64'(act_q.size()), 64'd0);
        chk("midrst_idle", 64'(dbg_state), 64'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            arm       = ($urandom_range(0, 29) == 0);
            abort     = ($urandom_range(0, 99) == 0);
            trig_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)
                capture_length = big_len[$urandom_range(0, 3)];
            else
                capture_length = 16'($urandom_range(0, 12));
            fc_orbitSync = ($urandom_range(0, 7) == 0);
            tvalid       = ($urandom_range(0, 3) != 0);
            tdata        = $urandom;
            reset        = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0; arm = 1'b0; abort = 1'b0;
        quiet(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_to_bram.md
STREAM_TO_BRAM -- requirements
Module: stream_to_bram

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 2048, capture buffer depth in 32-bit words.
REQ-002 SHALL have parameter AW, default $clog2(MEM_DEPTH), word-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port arm  input  1  single-cycle pulse that starts a capture sequence.
REQ-006 SHALL have port abort  input  1  single-cycle pulse that returns the block to IDLE.
REQ-007 SHALL have port trig_mode  input  1  trigger select: 0 = immediate, 1 = wait for orbit sync.
REQ-008 SHALL have port capture_length  input  16  number of words to capture.
REQ-009 SHALL have port fc_orbitSync  input  1  fast-command orbit sync pulse.
REQ-010 SHALL have port data_stream_TDATA  input  32  stream data.
REQ-011 SHALL have port data_stream_TVALID  input  1  stream valid.
REQ-012 SHALL have port data_stream_TREADY  output  1  stream ready.
REQ-013 SHALL have port bram_CLK  output  1  equal to clk.
REQ-014 SHALL have port bram_RST  output  1  equal to reset.
REQ-015 SHALL have port bram_EN  output  1  BRAM enable.
REQ-016 SHALL have port bram_WE  output  4  BRAM byte write enables.
REQ-017 SHALL have port bram_ADDR  output  32  BRAM byte address.
REQ-018 SHALL have port bram_DIN  output  32  BRAM write data.
REQ-019 SHALL have port busy  output  1  high in ARMED or CAPTURE.
REQ-020 SHALL have port done  output  1  high in DONE.
REQ-021 SHALL have port word_count  output  16  number of words written in the current or last capture.

Function
REQ-022 SHALL implement the states IDLE, ARMED, CAPTURE and DONE.
REQ-023 SHALL register fc_orbitSync once (sync_r); all trigger decisions SHALL use sync_r.
REQ-024 SHALL, on arm in IDLE or DONE, latch trig_mode, latch effective length L, clear word_count and write address, and enter ARMED.
REQ-025 SHALL ignore arm while in ARMED or CAPTURE.
REQ-026 SHALL set L = MEM_DEPTH when capture_length is 0 or greater than MEM_DEPTH, and L = capture_length otherwise.
REQ-027 SHALL, in ARMED, start capture on the first accepted beat (TVALID=1) when latched trig_mode=0, or on the first accepted beat with sync_r=1 when latched trig_mode=1; that beat SHALL be word 0.
REQ-028 SHALL discard accepted beats in ARMED that do not satisfy the trigger condition.
REQ-029 SHALL hold data_stream_TREADY = 1 in every state except during reset; the block SHALL never backpressure.
REQ-030 SHALL write every accepted beat in CAPTURE, including the trigger beat, at consecutive word addresses starting at 0.
REQ-031 SHALL register the BRAM write one cycle after acceptance: bram_EN=1, bram_WE=4'hF, bram_ADDR={word address, 2'b00} zero-extended to 32 bits, bram_DIN=beat data.
REQ-032 SHALL drive bram_EN=0 and bram_WE=0 in every cycle with no pending write.
REQ-033 SHALL increment word_count in the same cycle the write is issued.
REQ-034 SHALL enter DONE on the cycle the L-th write is issued, and SHALL ignore further beats until the next arm.
REQ-035 SHALL never write an address greater than or equal to MEM_DEPTH.
REQ-036 SHALL, on abort in any state, enter IDLE next cycle, cancel any write not yet issued, and hold word_count.
REQ-037 SHALL give abort priority when abort and arm occur in the same cycle.
REQ-038 SHALL treat a beat coincident with arm as not accepted for capture.

Reset
REQ-039 SHALL, while reset is asserted, asynchronously force state=IDLE, word_count=0, address=0, bram_EN=0, bram_WE=0, bram_DIN=0, bram_ADDR=0, busy=0, done=0 and data_stream_TREADY=0.
REQ-040 SHALL, on reset asserted mid-capture, abandon the capture and issue no further writes after deassertion until a new arm.

Verification
REQ-041 SHALL be verified for immediate trigger: trig_mode=0, capture_length=4, arm, continuous beats 0xA0..0xA5 -> writes 0xA0..0xA3 at byte addresses 0x0, 0x4, 0x8, 0xC; done=1; word_count=4.
REQ-042 SHALL be verified for orbit trigger: trig_mode=1, capture_length=3, fc_orbitSync pulsed while beat 0x55 is present -> 0x55 is not captured; the beat one cycle later (sync_r=1) is captured as word 0 at address 0x0.
REQ-043 SHALL be verified for length clamp: capture_length=0 and separately capture_length=5000 with MEM_DEPTH=2048 -> exactly 2048 writes, last at bram_ADDR=0x1FFC.
REQ-044 SHALL be verified for gapped stream and abort: TVALID toggling every other cycle with capture_length=8, abort after 3 writes -> state=IDLE, word_count=3, no further bram_WE.
REQ-045 SHALL be verified for re-arm and reset: arm in DONE restarts at address 0x0; reset mid-capture -> all outputs at REQ-039 values.
